// File: rtl/turfio_aurora_reset_seq_if.sv
// rtl/turfio_aurora_reset_seq_if.sv - Aurora reset sequencer link/control signal bundle
interface turfio_aurora_reset_seq_if;
    logic       pll_not_locked_i;
    logic       channel_up_i;
    logic       force_reset_i;
    logic       pma_init_o;
    logic       reset_pb_o;
    logic       link_ok_o;
    logic [7:0] retry_count_o;
    logic [2:0] state_o;

    modport master (
        input  pll_not_locked_i,
        input  channel_up_i,
        input  force_reset_i,
        output pma_init_o,
        output reset_pb_o,
        output link_ok_o,
        output retry_count_o,
        output state_o
    );

    modport slave (
        output pll_not_locked_i,
        output channel_up_i,
        output force_reset_i,
        input  pma_init_o,
        input  reset_pb_o,
        input  link_ok_o,
        input  retry_count_o,
        input  state_o
    );
endinterface

// File: rtl/turfio_aurora_reset_seq.sv
// rtl/turfio_aurora_reset_seq.sv - TURFIO Aurora pma_init/reset_pb sequencer with link supervision (optional AURORA_RESET_SEQ_DEBOUNCE_EN)
module turfio_aurora_reset_seq #(
    parameter int HOLD_CYCLES  = 64,
    parameter int WAIT_TIMEOUT = 1048576
) (
    input  logic                             user_clk_o,
    input  logic                             bufg_gt_clr_i,
    turfio_aurora_reset_seq_if.master        bus
);
    localparam int MAX_CYC = (HOLD_CYCLES > WAIT_TIMEOUT) ? HOLD_CYCLES : WAIT_TIMEOUT;
    localparam int CW      = $clog2(MAX_CYC) + 1;
    localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] WAIT_LAST = CW'(WAIT_TIMEOUT - 1);

    typedef enum logic [2:0] {
        ST_RESET   = 3'd0,
        ST_PMA_REL = 3'd1,
        ST_WAIT_UP = 3'd2,
        ST_UP      = 3'd3
    } state_t;

    state_t          state, state_n;
    logic [CW-1:0]   cnt;
    logic            cnt_clr;
    logic            retry_inc;
    logic            force_meta, force_sync, force_prev;
    logic            force_evt;
    logic            up_qual, down_qual;

    assign force_evt = force_sync & ~force_prev;

    // Two-flop synchroniser on the software reset request plus an edge flop
    always_ff @(posedge user_clk_o or posedge bufg_gt_clr_i) begin
        if (bufg_gt_clr_i) begin
            force_meta <= 1'b0;
            force_sync <= 1'b0;
            force_prev <= 1'b0;
        end else begin
            force_meta <= bus.force_reset_i;
            force_sync <= force_meta;
            force_prev <= force_sync;
        end
    end

`ifdef AURORA_RESET_SEQ_DEBOUNCE_EN
    logic [8:0] qual_cnt;
    logic       qual_match;

    // Qualifier counts consecutive cycles of the level that would move the FSM on
    assign qual_match = ((state == ST_WAIT_UP) &&  bus.channel_up_i) ||
                        ((state == ST_UP)      && !bus.channel_up_i);
    assign up_qual    = (state == ST_WAIT_UP) &&  bus.channel_up_i && (qual_cnt == 9'd255);
    assign down_qual  = (state == ST_UP)      && !bus.channel_up_i && (qual_cnt == 9'd15);

    // Restart qualification on any state change or when the level breaks
    always_ff @(posedge user_clk_o or posedge bufg_gt_clr_i) begin
        if (bufg_gt_clr_i)
            qual_cnt <= 9'd0;
        else if ((state_n != state) || !qual_match)
            qual_cnt <= 9'd0;
        else
            qual_cnt <= qual_cnt + 9'd1;
    end
`else
    assign up_qual   =  bus.channel_up_i;
    assign down_qual = ~bus.channel_up_i;
`endif

    // Next-state decode: PLL loss and software reset override the normal sequence
    always_comb begin
        state_n   = state;
        cnt_clr   = 1'b0;
        retry_inc = 1'b0;
        if (bus.pll_not_locked_i) begin
            state_n = ST_RESET;
            cnt_clr = 1'b1;
        end else if (force_evt) begin
            state_n = ST_RESET;
            cnt_clr = 1'b1;
        end else begin
            case (state)
                ST_RESET:   if (cnt == HOLD_LAST) state_n = ST_PMA_REL;
                ST_PMA_REL: if (cnt == HOLD_LAST) state_n = ST_WAIT_UP;
                ST_WAIT_UP: begin
                    if (up_qual) begin
                        state_n = ST_UP;
                    end else if (cnt == WAIT_LAST) begin
                        state_n   = ST_RESET;
                        retry_inc = 1'b1;
                    end
                end
                ST_UP: begin
                    if (down_qual) begin
                        state_n   = ST_RESET;
                        retry_inc = 1'b1;
                    end
                end
                default:    state_n = ST_RESET;
            endcase
        end
    end

    // State, shared phase counter and registered outputs all update together
    always_ff @(posedge user_clk_o or posedge bufg_gt_clr_i) begin
        if (bufg_gt_clr_i) begin
            state             <= ST_RESET;
            cnt               <= '0;
            bus.pma_init_o    <= 1'b1;
            bus.reset_pb_o    <= 1'b1;
            bus.link_ok_o     <= 1'b0;
            bus.retry_count_o <= 8'd0;
            bus.state_o       <= 3'd0;
        end else begin
            state <= state_n;
            if (cnt_clr || (state_n != state))
                cnt <= '0;
            else
                cnt <= cnt + CW'(1);
            if (retry_inc && (bus.retry_count_o != 8'hFF))
                bus.retry_count_o <= bus.retry_count_o + 8'd1;
            bus.pma_init_o <= (state_n == ST_RESET);
            bus.reset_pb_o <= (state_n == ST_RESET) || (state_n == ST_PMA_REL);
            bus.link_ok_o  <= (state_n == ST_UP);
            bus.state_o    <= state_n;
        end
    end
endmodule

// File: tb/tb_turfio_aurora_reset_seq.sv
// tb/tb_turfio_aurora_reset_seq.sv - scoreboard bench for turfio_aurora_reset_seq
module tb_turfio_aurora_reset_seq;
    localparam int HC = 4;
`ifdef AURORA_RESET_SEQ_DEBOUNCE_EN
    localparam int WT  = 512;
    localparam int QH  = 256;
    localparam int QL  = 16;
    localparam int NTO = 20;
`else
    localparam int WT  = 16;
    localparam int QH  = 1;
    localparam int QL  = 1;
    localparam int NTO = 300;
`endif

    logic user_clk_o    = 1'b0;
    logic bufg_gt_clr_i = 1'b1;

    turfio_aurora_reset_seq_if bus();

    turfio_aurora_reset_seq #(.HOLD_CYCLES(HC), .WAIT_TIMEOUT(WT)) dut (
        .user_clk_o    (user_clk_o),
        .bufg_gt_clr_i (bufg_gt_clr_i),
        .bus           (bus)
    );

    always #5 user_clk_o = ~user_clk_o;

    // reference model: phase 0 reset, 1 pma released, 2 waiting, 3 up
    int  m_phase, m_age, m_retry, m_run;
    bit  h0, h1, h2;
    logic [13:0] sb[$];
    int  total = 0;
    int  bad   = 0;

    function automatic logic [13:0] m_expect();
        return {3'(m_phase), (m_phase == 0), (m_phase <= 1), (m_phase == 3), 8'(m_retry)};
    endfunction

    task automatic check(input string what, input bit ok);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL %s t=%0t st=%0d pma=%b rpb=%b ok=%b rc=%0d model_rc=%0d",
                     what, $time, bus.state_o, bus.pma_init_o, bus.reset_pb_o,
                     bus.link_ok_o, bus.retry_count_o, m_retry);
        end
    endtask

    task automatic model_reset();
        m_phase = 0; m_age = 0; m_retry = 0; m_run = 0;
        h0 = 0; h1 = 0; h2 = 0;
    endtask

    task automatic enter(input int p);
        m_phase = p; m_age = 0; m_run = 0;
    endtask

    task automatic bump();
        if (m_retry < 255) m_retry = m_retry + 1;
    endtask

    task automatic model_step(input bit pll, input bit cu, input bit frc);
        bit evt;
        evt = h1 && !h2;
        h2 = h1; h1 = h0; h0 = frc;
        if (pll || evt) begin
            enter(0);
        end else begin
            case (m_phase)
                0: if (m_age == HC - 1) enter(1); else m_age++;
                1: if (m_age == HC - 1) enter(2); else m_age++;
                2: begin
                    m_run = cu ? m_run + 1 : 0;
                    if (m_run >= QH) enter(3);
                    else if (m_age == WT - 1) begin enter(0); bump(); end
                    else m_age++;
                end
                default: begin
                    m_run = !cu ? m_run + 1 : 0;
                    if (m_run >= QL) begin enter(0); bump(); end
                    else m_age++;
                end
            endcase
        end
    endtask

    task automatic drive_step(input bit pll, input bit cu, input bit frc);
        bus.pll_not_locked_i = pll;
        bus.channel_up_i     = cu;
        bus.force_reset_i    = frc;
        model_step(pll, cu, frc);
        sb.push_back(m_expect());
    endtask

    task automatic cycle(input bit pll, input bit cu, input bit frc);
        @(negedge user_clk_o);
        drive_step(pll, cu, frc);
    endtask

    task automatic goto_phase(input int p, input bit cu);
        for (int i = 0; i < 2000 && m_phase != p; i++) cycle(0, cu, 0);
    endtask

    // monitor: every clock edge (or async reset assertion) the DUT presents a new state
    initial begin
        logic [13:0] exp_v, act_v;
        forever begin
            @(posedge user_clk_o or posedge bufg_gt_clr_i);
            #1;
            if (sb.size() > 0) begin
                exp_v = sb.pop_front();
                act_v = {bus.state_o, bus.pma_init_o, bus.reset_pb_o, bus.link_ok_o, bus.retry_count_o};
                total++;
                if (act_v !== exp_v) begin
                    bad++;
                    $display("FAIL seq_out t=%0t got st=%0d pma=%b rpb=%b ok=%b rc=%0d want st=%0d pma=%b rpb=%b ok=%b rc=%0d",
                             $time, act_v[13:11], act_v[10], act_v[9], act_v[8], act_v[7:0],
                             exp_v[13:11], exp_v[10], exp_v[9], exp_v[8], exp_v[7:0]);
                end
            end
        end
    end

    initial begin
        bit cu_lvl, frc_lvl;
        bus.pll_not_locked_i = 1'b0;
        bus.channel_up_i     = 1'b0;
        bus.force_reset_i    = 1'b0;
        model_reset();
        repeat (3) @(negedge user_clk_o);
        check("reset_state", (bus.state_o === 3'd0) && (bus.pma_init_o === 1'b1) &&
                             (bus.reset_pb_o === 1'b1) && (bus.link_ok_o === 1'b0) &&
                             (bus.retry_count_o === 8'd0));
        // bring-up with channel_up arriving at cycle 12
        bufg_gt_clr_i = 1'b0;
        drive_step(0, 0, 0);
        for (int i = 1; i < 30; i++) cycle(0, i >= 11, 0);

        // repeated timeouts until the retry counter saturates
        for (int i = 0; i < NTO * (2 * HC + WT) + 40; i++) cycle(0, 0, 0);
        @(posedge user_clk_o);
        #1;
        check("wait_expired", (bus.retry_count_o === 8'(m_retry)) &&
                              ((QH > 1) || (bus.retry_count_o === 8'd255)));

        // PLL loss while up, then recovery
        goto_phase(3, 1);
        for (int i = 0; i < 20; i++) cycle(1, 1, 0);
        for (int i = 0; i < 30; i++) cycle(0, 1, 0);

        // level-held software reset while up gives a single event
        goto_phase(3, 1);
        for (int i = 0; i < 50; i++) cycle(0, 1, 1);
        for (int i = 0; i < 20; i++) cycle(0, 1, 0);

`ifdef AURORA_RESET_SEQ_DEBOUNCE_EN
        goto_phase(3, 1);
        for (int i = 0; i < 10; i++) cycle(0, 0, 0);
        for (int i = 0; i < 10; i++) cycle(0, 1, 0);
        for (int i = 0; i < 16; i++) cycle(0, 0, 0);
        goto_phase(2, 0);
        for (int i = 0; i < 255; i++) cycle(0, 1, 0);
        for (int i = 0; i < 10; i++) cycle(0, 0, 0);
`endif

        // randomized traffic
        cu_lvl = 1; frc_lvl = 0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, QL > 1 ? 63 : 7) == 0) cu_lvl = !cu_lvl;
            if ($urandom_range(0, 39) == 0) frc_lvl = !frc_lvl;
            cycle($urandom_range(0, 199) == 0, cu_lvl, frc_lvl);
        end

        // asynchronous reset in the middle of the pma-release phase
        goto_phase(1, 1);
        @(negedge user_clk_o);
        #2;
        model_reset();
        sb.push_back(m_expect());
        bufg_gt_clr_i = 1'b1;
        #1;
        check("async_reset", (bus.state_o === 3'd0) && (bus.pma_init_o === 1'b1) &&
                             (bus.reset_pb_o === 1'b1) && (bus.link_ok_o === 1'b0) &&
                             (bus.retry_count_o === 8'd0));
        repeat (3) @(negedge user_clk_o);
        bufg_gt_clr_i = 1'b0;
        drive_step(0, 1, 0);
        for (int i = 0; i < 40; i++) cycle(0, 1, 0);

        @(posedge user_clk_o);
        #3;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
